// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit-stage / CSR-file signals of the trap sequencer.
//   slave  : trap_ctrl side (takes commit events and CSR values, drives
//            stall, CSR strobes, redirect and flush)
//   master : pipeline/CSR side (the opposite directions)
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  // commit-stage event inputs
  logic            i_valid;
  logic [XLEN-1:0] i_pc;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_badaddr;
  logic            i_ex_inst_addr;
  logic            i_ex_illegal;
  logic            i_ecall;
  logic            i_ebreak;
  logic            i_ex_ld_addr;
  logic            i_ex_st_addr;
  logic            i_mret;
  logic            i_int_tip;
  logic            i_drain_done;
  // CSR file values
  logic [XLEN-1:0] i_tvec;
  logic [XLEN-1:0] i_mepc;
  // sequencer outputs
  logic            o_stall;
  logic            o_csr_trap;
  logic [XLEN-1:0] o_cause;
  logic [XLEN-1:0] o_tval;
  logic [XLEN-1:0] o_epc;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_flush;
  logic            o_eret;
  logic            o_drain_timeout;

  modport slave (
    input  i_valid, i_pc, i_inst, i_badaddr, i_ex_inst_addr, i_ex_illegal,
           i_ecall, i_ebreak, i_ex_ld_addr, i_ex_st_addr, i_mret, i_int_tip,
           i_drain_done, i_tvec, i_mepc,
    output o_stall, o_csr_trap, o_cause, o_tval, o_epc, o_redirect,
           o_redirect_pc, o_flush, o_eret, o_drain_timeout
  );

  modport master (
    output i_valid, i_pc, i_inst, i_badaddr, i_ex_inst_addr, i_ex_illegal,
           i_ecall, i_ebreak, i_ex_ld_addr, i_ex_st_addr, i_mret, i_int_tip,
           i_drain_done, i_tvec, i_mepc,
    input  o_stall, o_csr_trap, o_cause, o_tval, o_epc, o_redirect,
           o_redirect_pc, o_flush, o_eret, o_drain_timeout
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer between commit and the machine-mode CSR file.
// Picks the highest-priority trap of the committing instruction, stalls the
// front end while memory drains, strobes the CSR file, then redirects the PC
// to mtvec (trap) or mepc (MRET) with a pipeline flush.
//   i_clk, i_rst : clock, async active-high reset
//   bus (slave)  : commit events, drain status, mtvec/mepc in;
//                  stall, csr_trap/cause/tval/epc, redirect/flush/eret,
//                  sticky drain timeout out
module trap_ctrl #(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  trap_ctrl_if.slave  bus
);
  localparam int            CW   = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(DRAIN_MAX);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic [XLEN-1:0] epc;
  } trap_info_t;

  state_t     state, state_nxt;
  logic       kind_eret, kind_eret_nxt;   // 1: MRET sequence, 0: trap
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic       drain_hit;
  logic       lat_en, to_set;
  logic       timeout_q;
  trap_info_t info_q, ev;
  logic       trap_any;
  logic [XLEN-1:0] tgt;

  // Priority encode of the committing instruction's events.
  always_comb begin
    ev       = '0;
    ev.epc   = bus.i_pc;
    trap_any = 1'b1;
    if (bus.i_ex_inst_addr) begin
      ev.cause = XLEN'(0);
      ev.tval  = bus.i_badaddr;
    end else if (bus.i_ex_illegal) begin
      ev.cause = XLEN'(2);
      ev.tval  = XLEN'(bus.i_inst);
    end else if (bus.i_ebreak) begin
      ev.cause = XLEN'(3);
      ev.tval  = bus.i_pc;
    end else if (bus.i_ecall) begin
      ev.cause = XLEN'(11);
    end else if (bus.i_ex_ld_addr) begin
      ev.cause = XLEN'(4);
      ev.tval  = bus.i_badaddr;
    end else if (bus.i_ex_st_addr) begin
      ev.cause = XLEN'(6);
      ev.tval  = bus.i_badaddr;
    end else if (bus.i_int_tip) begin
      // interrupt is taken after the instruction retires
      ev.cause = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
      ev.epc   = bus.i_pc + XLEN'(4);
    end else begin
      trap_any = 1'b0;
    end
  end

  assign cnt_inc   = (cnt == CMAX) ? cnt : cnt + CW'(1);
  assign drain_hit = (cnt_inc == CMAX);

  always_comb begin
    state_nxt     = state;
    kind_eret_nxt = kind_eret;
    cnt_nxt       = cnt;
    lat_en        = 1'b0;
    to_set        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          if (trap_any) begin
            lat_en        = 1'b1;
            kind_eret_nxt = 1'b0;
            cnt_nxt       = '0;
            state_nxt     = DRAIN;
          end else if (bus.i_mret) begin
            kind_eret_nxt = 1'b1;
            cnt_nxt       = '0;
            state_nxt     = DRAIN;
          end
        end
      end
      DRAIN: begin
        cnt_nxt = cnt_inc;
        if (bus.i_drain_done || drain_hit) begin
          to_set    = drain_hit;
          state_nxt = kind_eret ? REDIRECT : COMMIT;
        end
      end
      COMMIT:   state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      kind_eret <= 1'b0;
      cnt       <= '0;
      info_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      kind_eret <= kind_eret_nxt;
      cnt       <= cnt_nxt;
      if (lat_en) info_q <= ev;
      if (to_set) timeout_q <= 1'b1;
    end
  end

  // Redirect target is taken from the CSR values present in REDIRECT.
  assign tgt = kind_eret ? bus.i_mepc : bus.i_tvec;

  always_comb begin
    bus.o_stall       = (state != IDLE);
    bus.o_csr_trap    = (state == COMMIT);
    bus.o_redirect    = (state == REDIRECT);
    bus.o_flush       = (state == REDIRECT);
    bus.o_eret        = (state == REDIRECT) && kind_eret;
    bus.o_redirect_pc = '0;
    if (state == REDIRECT) bus.o_redirect_pc = {tgt[XLEN-1:2], 2'b00};
  end

  assign bus.o_cause         = info_q.cause;
  assign bus.o_tval          = info_q.tval;
  assign bus.o_epc           = info_q.epc;
  assign bus.o_drain_timeout = timeout_q;
endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  localparam int XLEN      = 32;
  localparam int DRAIN_MAX = 15;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  trap_ctrl_if #(.XLEN(XLEN)) bus ();
  trap_ctrl #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
  );

  typedef struct {
    int          cyc;
    bit          csr;   // 1: csr_trap strobe, 0: redirect strobe
    bit          eret;
    logic [31:0] pc;
  } rec_t;

  rec_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   rnd_vec = 1'b0;

  // expected level-type outputs, maintained by the stimulus side
  logic        exp_stall = 1'b0;
  logic        exp_to    = 1'b0;
  logic [31:0] exp_cause = '0, exp_tval = '0, exp_epc = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    rec_t r;
    chk("stall", 32'(bus.o_stall), 32'(exp_stall));
    chk("drain_timeout", 32'(bus.o_drain_timeout), 32'(exp_to));
    chk("cause", bus.o_cause, exp_cause);
    chk("tval", bus.o_tval, exp_tval);
    chk("epc", bus.o_epc, exp_epc);
    if (i_rst) begin
      chk("rst_strobes", {bus.o_csr_trap, bus.o_redirect, bus.o_flush, bus.o_eret}, 0);
      chk("rst_redirect_pc", bus.o_redirect_pc, 0);
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      r = sb.pop_front();
      chk("strobe_cycle", cyc, r.cyc);
    end
    if (bus.o_csr_trap || bus.o_redirect || bus.o_flush || bus.o_eret) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {bus.o_csr_trap, bus.o_redirect, bus.o_flush, bus.o_eret}, 0);
      end else begin
        r = sb.pop_front();
        chk("strobe_cycle", cyc, r.cyc);
        chk("csr_trap", 32'(bus.o_csr_trap), 32'(r.csr));
        chk("redirect", 32'(bus.o_redirect), 32'(!r.csr));
        chk("flush", 32'(bus.o_flush), 32'(!r.csr));
        chk("eret", 32'(bus.o_eret), 32'(r.eret));
        if (!r.csr) chk("redirect_pc", bus.o_redirect_pc, r.pc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_ev();
    bus.i_valid = 0; bus.i_ex_inst_addr = 0; bus.i_ex_illegal = 0;
    bus.i_ecall = 0; bus.i_ebreak = 0; bus.i_ex_ld_addr = 0;
    bus.i_ex_st_addr = 0; bus.i_mret = 0; bus.i_int_tip = 0;
    bus.i_drain_done = 0;
  endtask

  // Arbitrary traffic while busy; the sequencer must ignore all of it.
  task automatic junk();
    bus.i_valid = 1'($urandom); bus.i_ex_inst_addr = 1'($urandom);
    bus.i_ex_illegal = 1'($urandom); bus.i_ecall = 1'($urandom);
    bus.i_ebreak = 1'($urandom); bus.i_ex_ld_addr = 1'($urandom);
    bus.i_ex_st_addr = 1'($urandom); bus.i_mret = 1'($urandom);
    bus.i_int_tip = 1'($urandom);
    bus.i_pc = $urandom; bus.i_inst = $urandom; bus.i_badaddr = $urandom;
    if (rnd_vec) begin bus.i_tvec = $urandom; bus.i_mepc = $urandom; end
  endtask

  task automatic rnd_idle();
    bus.i_valid        = ($urandom % 4) != 0;
    bus.i_ex_inst_addr = ($urandom % 10) == 0;
    bus.i_ex_illegal   = ($urandom % 10) == 0;
    bus.i_ecall        = ($urandom % 10) == 0;
    bus.i_ebreak       = ($urandom % 10) == 0;
    bus.i_ex_ld_addr   = ($urandom % 10) == 0;
    bus.i_ex_st_addr   = ($urandom % 10) == 0;
    bus.i_int_tip      = ($urandom % 8) == 0;
    bus.i_mret         = ($urandom % 4) == 0;
    bus.i_pc = $urandom; bus.i_inst = $urandom; bus.i_badaddr = $urandom;
    bus.i_tvec = $urandom; bus.i_mepc = $urandom;
  endtask

  // Called in an IDLE cycle with that cycle's inputs already driven.
  // Walks the whole expected sequence and queues the expected strobes.
  // dd_mode: 0 random drain_done, 1 always done, 2 never done.
  // rst_at>0: pulse reset in that DRAIN cycle instead of finishing.
  task automatic take(input int dd_mode, input int rst_at);
    bit trap, eret, hit;
    logic [31:0] c, tv, ep;
    int j;
    rec_t r;
    trap = 1; c = 0; tv = 0; ep = bus.i_pc;
    if (bus.i_ex_inst_addr)    begin c = 0;  tv = bus.i_badaddr; end
    else if (bus.i_ex_illegal) begin c = 2;  tv = bus.i_inst; end
    else if (bus.i_ebreak)     begin c = 3;  tv = bus.i_pc; end
    else if (bus.i_ecall)      begin c = 11; tv = 0; end
    else if (bus.i_ex_ld_addr) begin c = 4;  tv = bus.i_badaddr; end
    else if (bus.i_ex_st_addr) begin c = 6;  tv = bus.i_badaddr; end
    else if (bus.i_int_tip)    begin c = 32'h8000_0007; tv = 0; ep = bus.i_pc + 32'd4; end
    else trap = 0;
    eret = !trap && bus.i_mret;
    if (!bus.i_valid || !(trap || eret)) begin
      next_cycle();
      clear_ev();
      return;
    end
    next_cycle();
    exp_stall = 1;
    if (trap) begin exp_cause = c; exp_tval = tv; exp_epc = ep; end
    j = 1;
    hit = 0;
    forever begin
      junk();
      case (dd_mode)
        0:       bus.i_drain_done = ($urandom % 3) == 0;
        1:       bus.i_drain_done = 1;
        default: bus.i_drain_done = 0;
      endcase
      if (j == rst_at) begin
        clear_ev();
        i_rst = 1;
        exp_stall = 0; exp_to = 0; exp_cause = 0; exp_tval = 0; exp_epc = 0;
        repeat (2) next_cycle();
        i_rst = 0;
        return;
      end
      hit = (j == DRAIN_MAX);
      if (bus.i_drain_done || hit) break;
      next_cycle();
      j++;
    end
    next_cycle();
    if (hit) exp_to = 1;
    if (trap) begin
      junk();
      r.cyc = cyc; r.csr = 1; r.eret = 0; r.pc = 0;
      sb.push_back(r);
      next_cycle();
    end
    junk();
    r.cyc = cyc; r.csr = 0; r.eret = eret;
    r.pc = (eret ? bus.i_mepc : bus.i_tvec) & 32'hFFFF_FFFC;
    sb.push_back(r);
    next_cycle();
    exp_stall = 0;
    clear_ev();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ev();
    bus.i_pc = 0; bus.i_inst = 0; bus.i_badaddr = 0; bus.i_tvec = 0; bus.i_mepc = 0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 0;
    next_cycle();

    // ecall with immediate drain: trap commit at N+2, redirect at N+3
    rnd_vec = 0;
    bus.i_valid = 1; bus.i_ecall = 1; bus.i_pc = 32'h100; bus.i_tvec = 32'h201;
    take(1, 0);

    // inst-addr beats ld-addr and interrupt; interrupt taken next idle
    bus.i_valid = 1; bus.i_ex_inst_addr = 1; bus.i_ex_ld_addr = 1;
    bus.i_int_tip = 1; bus.i_badaddr = 32'h33; bus.i_pc = 32'h400;
    take(1, 0);
    bus.i_valid = 1; bus.i_int_tip = 1; bus.i_pc = 32'h500;
    take(1, 0);

    // interrupt at top of address space: epc wraps to 0
    bus.i_valid = 1; bus.i_int_tip = 1; bus.i_pc = 32'hFFFF_FFFC;
    take(1, 0);

    // MRET: no CSR trap strobe, redirect to mepc at N+2
    bus.i_valid = 1; bus.i_mret = 1; bus.i_mepc = 32'h444;
    take(1, 0);

    // random traffic
    rnd_vec = 1;
    repeat (150) begin rnd_idle(); take(0, 0); end

    // drain never completes: forced advance after DRAIN_MAX cycles
    rnd_vec = 0;
    bus.i_valid = 1; bus.i_ebreak = 1; bus.i_pc = 32'h800; bus.i_tvec = 32'h1000;
    take(2, 0);
    rnd_vec = 1;
    repeat (40) begin rnd_idle(); take(0, 0); end

    // reset mid-drain, then normal operation resumes
    bus.i_valid = 1; bus.i_ecall = 1; bus.i_pc = 32'h900;
    take(2, 3);
    repeat (150) begin rnd_idle(); take(0, 0); end

    clear_ev();
    repeat (3) next_cycle();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
